// File: rtl/config_pkg.sv
// Shared types and constants for the configuration word path.
package config_pkg;

  localparam int unsigned CONFIG_WORD_W = 32;
  localparam int unsigned CONFIG_BYTE_W = 8;
  localparam int unsigned CONFIG_CNT_W  = 2;

  localparam logic [CONFIG_WORD_W-1:0] CONFIG_SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

  // Big-endian shift: the newest byte lands in the low byte lane.
  function automatic logic [CONFIG_WORD_W-1:0] shift_in_byte(
    input logic [CONFIG_WORD_W-1:0] shift,
    input logic [CONFIG_BYTE_W-1:0] rx_byte
  );
    return {shift[CONFIG_WORD_W-CONFIG_BYTE_W-1:0], rx_byte};
  endfunction

endpackage

// File: rtl/config_idle_timer.sv
// Idle-cycle counter with expiry flag; counts enabled cycles since the last clear.
module config_idle_timer #(
  parameter int unsigned TimeoutCycles = 10000,
  parameter int unsigned TimeoutWidth  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired_c
);

  logic [TimeoutWidth-1:0] count_d, count_q;

  assign expired_c = enable && (count_q == TimeoutWidth'(TimeoutCycles - 1));

  // Held at zero while disabled; restarts after a clear or an expiry.
  always_comb begin
    count_d = count_q + TimeoutWidth'(1);
    if (!enable || clear || expired_c) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/config_word_assembler.sv
// Packs received bytes into big-endian 32-bit config words and tracks link activity.
// Optional sync-word realignment is enabled by defining CONFIG_SYNC_REALIGN_EN.
module config_word_assembler
  import config_pkg::*;
#(
  parameter int unsigned               TimeoutCycles = 10000,
  parameter int unsigned               TimeoutWidth  = 16,
  parameter logic [CONFIG_WORD_W-1:0]  SyncPattern   = CONFIG_SYNC_WORD
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [CONFIG_BYTE_W-1:0] RxByte,
  input  logic                     RxValid,
  output logic [CONFIG_WORD_W-1:0] WriteData,
  output logic                     WriteStrobe,
  output logic                     ComActive,
  output logic [CONFIG_CNT_W-1:0]  ByteCount
);

  link_state_e              state_d, state_q;
  logic [CONFIG_WORD_W-1:0] shift_d, shift_q;
  logic [CONFIG_WORD_W-1:0] wdata_d, wdata_q;
  logic                     strobe_d, strobe_q;
  logic [CONFIG_CNT_W-1:0]  count_d, count_q;
  logic [CONFIG_WORD_W-1:0] assembled_c;
  logic                     expired_c;

  config_idle_timer #(
    .TimeoutCycles(TimeoutCycles),
    .TimeoutWidth (TimeoutWidth)
  ) u_idle_timer (
    .clk      (CLK),
    .reset    (Reset),
    .enable   (state_q == ACTIVE),
    .clear    (RxValid),
    .expired_c(expired_c)
  );

  assign assembled_c = shift_in_byte(shift_q, RxByte);

`ifndef CONFIG_SYNC_REALIGN_EN
  logic unused_sync_c;
  assign unused_sync_c = ^SyncPattern;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (RxValid) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // A byte on the expiry cycle keeps the link alive.
        if (!RxValid && expired_c) begin
          state_d = IDLE;
          count_d = '0;
          shift_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (RxValid) begin
      shift_d = assembled_c;
      count_d = count_q + CONFIG_CNT_W'(1);
      if (count_q == CONFIG_CNT_W'(3)) begin
        wdata_d  = assembled_c;
        strobe_d = 1'b1;
      end
`ifdef CONFIG_SYNC_REALIGN_EN
      // Sync word seen at any byte offset forces word alignment here.
      if (assembled_c == SyncPattern) begin
        wdata_d  = SyncPattern;
        strobe_d = 1'b1;
        count_d  = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      wdata_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign WriteData   = wdata_q;
  assign WriteStrobe = strobe_q;
  assign ComActive   = (state_q == ACTIVE);
  assign ByteCount   = count_q;

endmodule
